// File: rtl/dma_mm_copy_engine.sv
// dma_mm_copy_engine: Avalon-MM memory-to-memory word copy through a credit-limited FIFO; DMA_IRQ_EN adds irq and the IE bit
module dma_mm_copy_engine #(
  parameter int FIFO_DEPTH = 8,
  parameter int LEN_W      = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  csr_address,
  input  logic        csr_read,
  input  logic        csr_write,
  input  logic [31:0] csr_writedata,
  output logic [31:0] csr_readdata,
  output logic [31:0] rd_address,
  output logic        rd_read,
  input  logic        rd_waitrequest,
  input  logic [31:0] rd_readdata,
  input  logic        rd_readdatavalid,
  output logic [31:0] wr_address,
  output logic        wr_write,
  output logic [31:0] wr_writedata,
  output logic [3:0]  wr_byteenable,
  input  logic        wr_waitrequest
`ifdef DMA_IRQ_EN
  ,
  output logic        irq
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE_ST} state_t;
  state_t state;
  logic done, ie, busy, go, acc_r, acc_w, push, credit;
  logic [31:0] src, dst, rdata;
  logic [LEN_W-1:0] len, rd_left, left_n;
  logic [AW:0] cnt, cnt_n, outs, outs_n;
  logic [AW-1:0] wptr, rptr;
  logic [31:0] mem [FIFO_DEPTH];
  assign busy = state == RUN;
  assign acc_r = rd_read & ~rd_waitrequest;
  assign acc_w = wr_write & ~wr_waitrequest;
  assign push = busy & rd_readdatavalid;
  assign go = csr_write & (csr_address == 3'd4) & csr_writedata[0] & ~busy;
  assign cnt_n = cnt + (AW+1)'(push) - (AW+1)'(acc_w);
  assign outs_n = outs + (AW+1)'(acc_r) - (AW+1)'(push);
  assign left_n = rd_left - LEN_W'(acc_r);
  // FIFO slots already holding data or promised to in-flight reads gate new reads
  assign credit = ({1'b0, cnt_n} + {1'b0, outs_n}) < (AW+2)'(FIFO_DEPTH);
  assign wr_writedata = mem[rptr];
  assign wr_byteenable = 4'hf;
`ifdef DMA_IRQ_EN
  assign irq = done & ie;
`else
  assign ie = 1'b0;
`endif
  always_comb
    rdata = csr_address == 3'd0 ? {30'd0, done, busy} :
            csr_address == 3'd1 ? src :
            csr_address == 3'd2 ? dst :
            csr_address == 3'd3 ? 32'(len) :
            csr_address == 3'd4 ? {30'd0, ie, 1'b0} : 32'd0;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      done <= 1'b0;
      src <= '0;
      dst <= '0;
      len <= '0;
      rd_left <= '0;
      cnt <= '0;
      outs <= '0;
      wptr <= '0;
      rptr <= '0;
      csr_readdata <= '0;
      rd_read <= 1'b0;
      wr_write <= 1'b0;
      rd_address <= '0;
      wr_address <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
`ifdef DMA_IRQ_EN
      ie <= 1'b0;
`endif
    end else begin
      csr_readdata <= csr_read ? rdata : 32'd0;
      if (csr_write && csr_address == 3'd0) done <= 1'b0;
`ifdef DMA_IRQ_EN
      if (csr_write && csr_address == 3'd4) ie <= csr_writedata[1];
`endif
      if (busy) begin
        rd_read <= (left_n != '0) && credit;
        wr_write <= cnt_n != '0;
        rd_left <= left_n;
        cnt <= cnt_n;
        outs <= outs_n;
        if (acc_r) rd_address <= rd_address + 32'd4;
        if (push) begin
          mem[wptr] <= rd_readdata;
          wptr <= wptr + AW'(1);
        end
        // LEN doubles as the remaining-write counter, so it reads back 0 when done
        if (acc_w) begin
          rptr <= rptr + AW'(1);
          wr_address <= wr_address + 32'd4;
          len <= len - LEN_W'(1);
          if (len == LEN_W'(1)) state <= DONE_ST;
        end
      end else begin
        if (state == DONE_ST) begin
          done <= 1'b1;
          state <= IDLE;
        end
        if (csr_write && csr_address == 3'd1) src <= {csr_writedata[31:2], 2'b00};
        if (csr_write && csr_address == 3'd2) dst <= {csr_writedata[31:2], 2'b00};
        if (csr_write && csr_address == 3'd3) len <= csr_writedata[LEN_W-1:0];
        if (go && len != '0) begin
          state <= RUN;
          done <= 1'b0;
          rd_read <= 1'b1;
          rd_left <= len;
          rd_address <= src;
          wr_address <= dst;
        end else if (go) done <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_dma_mm_copy_engine.sv
// tb_dma_mm_copy_engine: CSR vector table, directed corner cases and randomized copies against a word-level copy model
module tb_dma_mm_copy_engine;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [2:0] csr_address = '0;
  logic csr_read = 1'b0, csr_write = 1'b0;
  logic [31:0] csr_writedata = '0, csr_readdata;
  logic [31:0] rd_address, rd_readdata, wr_address, wr_writedata;
  logic rd_read, rd_waitrequest, rd_readdatavalid, wr_write, wr_waitrequest;
  logic [3:0] wr_byteenable;
`ifdef DMA_IRQ_EN
  logic irq;
  localparam logic [31:0] IE_R = 32'h2;
`else
  localparam logic [31:0] IE_R = 32'h0;
`endif

  dma_mm_copy_engine dut (
    .clk(clk), .reset_n(reset_n),
    .csr_address(csr_address), .csr_read(csr_read), .csr_write(csr_write),
    .csr_writedata(csr_writedata), .csr_readdata(csr_readdata),
    .rd_address(rd_address), .rd_read(rd_read), .rd_waitrequest(rd_waitrequest),
    .rd_readdata(rd_readdata), .rd_readdatavalid(rd_readdatavalid),
    .wr_address(wr_address), .wr_write(wr_write), .wr_writedata(wr_writedata),
    .wr_byteenable(wr_byteenable), .wr_waitrequest(wr_waitrequest)
`ifdef DMA_IRQ_EN
    , .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] ram [1024];
  logic [31:0] rd_log[$], wr_log_a[$], wr_log_d[$], exp_d[$];
  logic rd_rand = 1'b0, wr_rand = 1'b0, wr_hold = 1'b0, prev_wait = 1'b0;
  logic [31:0] prev_addr = '0, cur_src = '0, cur_dst = '0;
  int checks = 0, errors = 0, stab_err = 0, pulses = 0;

  // 1-cycle-latency RAM slave with optional random waitrequests, plus bus monitors
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_readdatavalid <= 1'b0;
      rd_readdata <= '0;
      rd_waitrequest <= 1'b0;
      wr_waitrequest <= 1'b0;
      prev_wait = 1'b0;
    end else begin
      if (prev_wait && (!rd_read || rd_address != prev_addr)) stab_err++;
      prev_wait = rd_read && rd_waitrequest;
      prev_addr = rd_address;
      if (rd_read || wr_write) pulses++;
      rd_readdatavalid <= rd_read && !rd_waitrequest;
      rd_readdata <= ram[rd_address[11:2]];
      if (rd_read && !rd_waitrequest) rd_log.push_back(rd_address);
      if (wr_write && !wr_waitrequest) begin
        ram[wr_address[11:2]] = wr_writedata;
        wr_log_a.push_back(wr_address);
        wr_log_d.push_back(wr_writedata);
      end
      rd_waitrequest <= rd_rand && ($urandom_range(0, 1) == 1);
      wr_waitrequest <= wr_hold || (wr_rand && $urandom_range(0, 3) == 0);
    end
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
    csr_address = a;
    csr_writedata = d;
    csr_write = 1'b1;
    @(negedge clk);
    csr_write = 1'b0;
  endtask

  task automatic csr_rd(input logic [2:0] a, output logic [31:0] d);
    csr_address = a;
    csr_read = 1'b1;
    @(negedge clk);
    csr_read = 1'b0;
    d = csr_readdata;
  endtask

  task automatic fill_src(input logic [31:0] src, input int len);
    for (int i = 0; i < len; i++) ram[(int'(src[11:2]) + i) % 1024] = $urandom();
  endtask

  task automatic start_xfer(input logic [31:0] src, input logic [31:0] dst, input int len);
    rd_log.delete();
    wr_log_a.delete();
    wr_log_d.delete();
    exp_d.delete();
    cur_src = src;
    cur_dst = dst;
    for (int i = 0; i < len; i++) exp_d.push_back(ram[(int'(src[11:2]) + i) % 1024]);
    csr_wr(3'd1, src);
    csr_wr(3'd2, dst);
    csr_wr(3'd3, 32'(len));
    csr_wr(3'd4, 32'h1);
  endtask

  // Polls STATUS until DONE; returns how many polls saw BUSY
  task automatic finish_xfer(input string n, input int len, output int busy_n);
    logic [31:0] s;
    int e;
    busy_n = 0;
    s = '0;
    for (int i = 0; i < 3000 && s[1:0] != 2'b10; i++) begin
      csr_rd(3'd0, s);
      if (s[0]) busy_n++;
    end
    if (s[1:0] != 2'b10) chk({n, "_timeout"}, s, 32'h2);
    e = 0;
    if (rd_log.size() != len || wr_log_a.size() != len) e++;
    else
      for (int i = 0; i < len; i++) begin
        if (rd_log[i] != cur_src + 32'(4 * i)) e++;
        if (wr_log_a[i] != cur_dst + 32'(4 * i)) e++;
        if (wr_log_d[i] != exp_d[i]) e++;
        if (ram[(int'(cur_dst[11:2]) + i) % 1024] != exp_d[i]) e++;
      end
    if (e != 0) $display("%s: %0d reads, %0d writes, %0d bad words", n, rd_log.size(), wr_log_a.size(), e);
    chk({n, "_copy_errs"}, 32'(e), 32'd0);
  endtask

  typedef struct {
    logic wr;
    logic [2:0] a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[12];

  initial begin
    logic [31:0] s, src, dst;
    int bn, len;
    vecs[0]  = '{1'b0, 3'd0, 32'h0, 32'h0};
    vecs[1]  = '{1'b0, 3'd1, 32'h0, 32'h0};
    vecs[2]  = '{1'b0, 3'd2, 32'h0, 32'h0};
    vecs[3]  = '{1'b0, 3'd3, 32'h0, 32'h0};
    vecs[4]  = '{1'b0, 3'd4, 32'h0, 32'h0};
    vecs[5]  = '{1'b1, 3'd1, 32'h0000_0123, 32'h0000_0120};
    vecs[6]  = '{1'b1, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFC};
    vecs[7]  = '{1'b1, 3'd3, 32'h0001_2345, 32'h0000_2345};
    vecs[8]  = '{1'b1, 3'd5, 32'hDEAD_BEEF, 32'h0};
    vecs[9]  = '{1'b0, 3'd7, 32'h0, 32'h0};
    vecs[10] = '{1'b1, 3'd4, 32'h2, IE_R};
    vecs[11] = '{1'b1, 3'd4, 32'h0, 32'h0};
    for (int i = 0; i < 1024; i++) ram[i] = '0;
    repeat (3) @(negedge clk);
    chk("reset_rd_address", rd_address, 32'h0);
    chk("reset_strobes", {30'd0, rd_read, wr_write}, 32'h0);
    chk("reset_wr_writedata", wr_writedata, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);
    foreach (vecs[i]) begin
      if (vecs[i].wr) csr_wr(vecs[i].a, vecs[i].d);
      csr_rd(vecs[i].a, s);
      chk($sformatf("csr_vec%0d", i), s, vecs[i].exp);
    end
    // Basic 4-word copy, zero wait states
    for (int i = 0; i < 4; i++) ram[i] = 32'h11 * (i + 1);
    start_xfer(32'h0, 32'h100, 4);
    finish_xfer("basic", 4, bn);
    chk("basic_busy_le8", 32'(bn > 0 && bn <= 8), 32'h1);
    for (int i = 0; i < 4; i++) chk($sformatf("basic_dst%0d", i), ram[64 + i], 32'h11 * (i + 1));
    csr_rd(3'd0, s);
    chk("basic_status_done", s, 32'h2);
    csr_rd(3'd3, s);
    chk("basic_len_zero", s, 32'h0);
`ifdef DMA_IRQ_EN
    csr_wr(3'd4, 32'h2);
    chk("irq_set", 32'(irq), 32'h1);
    csr_wr(3'd0, 32'h0);
    chk("irq_clear", 32'(irq), 32'h0);
    csr_wr(3'd4, 32'h0);
`endif
    // GO with LEN=0: DONE without any bus activity
    csr_wr(3'd0, 32'h0);
    csr_rd(3'd0, s);
    chk("done_cleared", s, 32'h0);
    csr_wr(3'd3, 32'h0);
    pulses = 0;
    csr_wr(3'd4, 32'h1);
    csr_rd(3'd0, s);
    chk("len0_done", s, 32'h2);
    repeat (5) @(negedge clk);
    chk("len0_no_pulses", 32'(pulses), 32'h0);
    // Write side held off: FIFO fills and reads stop at FIFO_DEPTH
    fill_src(32'h200, 32);
    wr_hold = 1'b1;
    start_xfer(32'h200, 32'h800, 32);
    repeat (20) @(negedge clk);
    chk("full_rd_read_low", 32'(rd_read), 32'h0);
    chk("full_reads_accepted", 32'(rd_log.size()), 32'd8);
    chk("full_no_writes", 32'(wr_log_a.size()), 32'd0);
    wr_hold = 1'b0;
    finish_xfer("stall32", 32, bn);
    // Random read waitrequests
    fill_src(32'h400, 16);
    rd_rand = 1'b1;
    start_xfer(32'h400, 32'hA00, 16);
    finish_xfer("rdwait", 16, bn);
    rd_rand = 1'b0;
    chk("rdwait_reads", 32'(rd_log.size()), 32'd16);
    chk("rdwait_addr_stable", 32'(stab_err), 32'h0);
    // GO and LEN while busy are ignored
    fill_src(32'h300, 12);
    wr_rand = 1'b1;
    start_xfer(32'h300, 32'hC00, 12);
    csr_wr(3'd3, 32'd5);
    csr_wr(3'd4, 32'h1);
    finish_xfer("go_busy", 12, bn);
    wr_rand = 1'b0;
    csr_rd(3'd3, s);
    chk("go_busy_len_zero", s, 32'h0);
    // Async reset mid-transfer, then a clean restart
    fill_src(32'h500, 8);
    start_xfer(32'h500, 32'hD00, 8);
    for (int k = 0; k < 500 && wr_log_a.size() < 3; k++) @(negedge clk);
    chk("rst_three_writes", 32'(wr_log_a.size() >= 3), 32'h1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_strobes", {30'd0, rd_read, wr_write}, 32'h0);
    chk("rst_rd_address", rd_address, 32'h0);
    chk("rst_wr_address", wr_address, 32'h0);
    chk("rst_wr_writedata", wr_writedata, 32'h0);
    chk("rst_csr_readdata", csr_readdata, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    csr_rd(3'd0, s);
    chk("rst_status", s, 32'h0);
    csr_rd(3'd3, s);
    chk("rst_len", s, 32'h0);
    fill_src(32'h500, 8);
    start_xfer(32'h500, 32'hE00, 8);
    finish_xfer("after_reset", 8, bn);
    // Randomized transfers, including source and destination address wrap
    for (int t = 0; t < 12; t++) begin
      len = $urandom_range(1, 40);
      src = t == 0 ? 32'hFFFF_FFF0 : t == 1 ? 32'h0000_0190 :
            ($urandom() & 32'hFFFF_F000) | 32'($urandom_range(0, 200) * 4);
      dst = t == 1 ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_F000) | 32'($urandom_range(512, 700) * 4);
      rd_rand = 1'($urandom_range(0, 1));
      wr_rand = 1'($urandom_range(0, 1));
      fill_src(src, len);
      start_xfer(src, dst, len);
      finish_xfer($sformatf("rand%0d", t), len, bn);
    end
    rd_rand = 1'b0;
    wr_rand = 1'b0;
    chk("rand_addr_stable", 32'(stab_err), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
